// File: rtl/clkctl_pkg.sv
// Shared types and constants for the front-panel clock controller.
// Optional build macro CLKCTL_RESUME_EN is consumed by clock_control.
package clkctl_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PULSE    = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

endpackage

// File: rtl/clkctl_debounce.sv
// Two-flop synchroniser followed by a saturating-mismatch debouncer.
// The stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module clkctl_debounce
  import clkctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Any sample matching the stable value restarts the qualification window
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_control.sv
// Front-panel controller: debounced step button -> fixed-width push pulse, gated mode select, sticky halt.
// Define CLKCTL_RESUME_EN to let a manual-mode press clear a pending halt instead of stepping.
module clock_control
  import clkctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic mode_raw,
  input  logic hlt_req,
  output logic push,
  output logic select,
  output logic hlt,
  output logic busy
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic          btn_db;
  logic          mode_db;
  logic          btn_d;
  logic          press;
  logic          resume;
  state_t        state;
  logic [PW-1:0] pcnt;

  clkctl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_raw),
    .stable (btn_db)
  );

  clkctl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (mode_raw),
    .stable (mode_db)
  );

  assign press = btn_db & ~btn_d;

`ifdef CLKCTL_RESUME_EN
  assign resume = press && (state == IDLE) && hlt && !select;
`else
  assign resume = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      btn_d  <= 1'b0;
      push   <= 1'b0;
      select <= 1'b0;
      hlt    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      btn_d <= btn_db;
      busy  <= (state != IDLE);
      push  <= 1'b0;

      // A new halt request outranks a resume press in the same cycle
      if (hlt_req) begin
        hlt <= 1'b1;
      end else if (resume) begin
        hlt <= 1'b0;
      end

      if (state == IDLE) begin
        select <= mode_db;
      end

      case (state)
        IDLE: begin
          if (press) begin
            if (select || hlt || hlt_req) begin
              state <= WAIT_REL;
            end else begin
              state <= PULSE;
              pcnt  <= PW'(PULSE_CYCLES - 1);
              push  <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (pcnt == '0) begin
            state <= WAIT_REL;
          end else begin
            pcnt <= pcnt - 1'b1;
            push <= 1'b1;
          end
        end
        WAIT_REL: begin
          if (!btn_db) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clock_control.md
Name: clock_control

Overview:
Front-panel controller that drives the `clock_module` inputs `select`, `hlt` and `push` from raw board signals.
- Synchronises and debounces the manual step button and the astable/manual mode switch.
- Turns each clean button press into one fixed-width `push` pulse.
- Latches the halt request from the control-word HLT bit.
- Runs on the free-running board oscillator, not on the computer clock it controls.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips (>=2).
PULSE_CYCLES, 4, width in clk cycles of each `push` pulse (>=1).

Ports:
clk  input  1  board oscillator clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
btn_raw  input  1  raw manual-step pushbutton, 1 = pressed, bouncy, asynchronous.
mode_raw  input  1  raw mode switch, 1 = astable, 0 = manual, bouncy, asynchronous.
hlt_req  input  1  HLT control bit, synchronous to clk.
push  output  1  step pulse to the clock module.
select  output  1  debounced mode: 1 = astable, 0 = manual.
hlt  output  1  sticky halt to the clock module.
busy  output  1  high whenever the step FSM is not in IDLE.

Behaviour:
Interface:
- Single clock `clk`.
- `rst` is asynchronous, active-high.
- All outputs are registered.

Reset values:
- push=0, select=0, hlt=0, busy=0.
- Both stable debounced values = 0; all counters = 0; FSM = IDLE.
- Reset asserted mid-pulse kills the pulse immediately. After release the FSM restarts from IDLE, and a button still held is seen as a new press only after debounce.

Synchroniser:
- `btn_raw` and `mode_raw` each pass through a 2-flop synchroniser.

Debouncer (one per input):
- Counter of width clog2(DEBOUNCE_CYCLES).
- Cleared whenever the synchronised value equals the stable value.
- Incremented while they differ.
- When it reaches DEBOUNCE_CYCLES-1 and they still differ: the stable value flips and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never changes the stable value.

Step FSM:
- IDLE: on debounced button 0->1, go to PULSE. The pulse counter loads PULSE_CYCLES-1.
- PULSE: `push` is 1 for exactly PULSE_CYCLES cycles. Counter decrements; at 0, go to WAIT_REL.
- WAIT_REL: stay until debounced button = 0, then go to IDLE.
- Latency: the raw edge is captured at cycle 0; `push` first reads 1 at cycle 2 + DEBOUNCE_CYCLES + 1.
- Suppression:
  - A press seen while select=1 or hlt=1 goes IDLE->WAIT_REL directly, with no pulse.
  - Holding the button yields exactly one pulse.
  - A pulse in progress is never truncated by hlt or a mode change.

select:
- Follows the debounced mode value only while the FSM is in IDLE; otherwise it holds.
- A mode change during PULSE/WAIT_REL takes effect on the first IDLE cycle.

hlt:
- Set on the clk edge where hlt_req=1; hlt reads 1 the cycle after hlt_req is sampled high.
- Sticky; cleared only by rst (see optional feature).
- hlt_req=1 and a press in the same cycle: hlt wins, and that press produces no pulse.

busy:
- Combinational decode of registered state != IDLE, re-registered.
- Lags the state by one cycle.

Optional Feature:
Macro CLKCTL_RESUME_EN.
- Defined: a debounced press while hlt=1 and select=0 clears hlt on the next cycle and produces no push pulse. FSM goes to WAIT_REL. hlt_req=1 in that same cycle keeps hlt set (set has priority).
- Undefined: hlt clears only on rst.

Decomposition:
- Shared package `clkctl_pkg`: state enum (IDLE, PULSE, WAIT_REL, 2-bit encoding 00/01/10) and the synchroniser depth constant SYNC_STAGES=2.
- One natural sub-module, `clkctl_debounce` (synchroniser + debounce counter + stable register, parameter DEBOUNCE_CYCLES), instantiated twice.
- FSM, halt latch and select gating live in the top module.

Test Plan:
- DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, select=0: assert btn_raw at cycle 0, hold 30 cycles -> push high in cycles 7-9 only, busy high until release is debounced, exactly one pulse.
- btn_raw bounces 0/1 every 2 cycles for 20 cycles, then held 1 -> no push during bouncing; exactly one 3-cycle pulse once it has been stable for 4 cycles.
- mode_raw=1 (select=1), press button -> push stays 0; toggle mode_raw to 0 mid-press -> select changes only after busy drops; next press pulses.
- hlt_req=1 for one cycle -> hlt=1 the following cycle and stays 1; subsequent presses -> no push; rst -> hlt=0.
- Assert rst during cycle 8 of a pulse -> push=0 immediately; after release with button still held -> one new pulse after full debounce latency.
- CLKCTL_RESUME_EN defined, hlt=1, select=0, press -> hlt=0 one cycle after debounced press, push never asserted; the next press pulses normally.
